// File: rtl/uart_rx_pkg.sv
// Shared types, constants and helpers for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8       = 32'd8;
    localparam int unsigned PRESCALE_16      = 32'd16;
    localparam int unsigned PRESCALE_32      = 32'd32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_8;

    function automatic int unsigned legal_prescale(input int unsigned p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: legal_prescale = p;
            default:                              legal_prescale = PRESCALE_DEFAULT;
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_core_rx_bit_sampler.sv
// Captures three mid-bit samples and presents their majority vote.
module rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sampled_bit,
    output logic                      sample_done
);

    logic [PRESCALE_WIDTH-1:0] half_s;
    logic [2:0]                samples_r;
    logic                      sample_done_r;

    assign half_s = prescale >> 1;

    // Capture at P/2-1, P/2, P/2+1; done is high in the P/2+2 cycle when the vote is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_r     <= 3'b111;
            sample_done_r <= 1'b0;
        end else begin
            if (edge_cnt == half_s - PRESCALE_WIDTH'(1)) begin
                samples_r[0] <= rx;
            end else if (edge_cnt == half_s) begin
                samples_r[1] <= rx;
            end else if (edge_cnt == half_s + PRESCALE_WIDTH'(1)) begin
                samples_r[2] <= rx;
            end else begin
                samples_r <= samples_r;
            end
            sample_done_r <= (edge_cnt == half_s + PRESCALE_WIDTH'(1));
        end
    end

    assign sampled_bit = majority3(samples_r);
    assign sample_done = sample_done_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled, majority-voted, optional parity, registered result pulses.
// Data_Valid appears exactly 2 + 1 + P*(1+DATA_WIDTH+PAR_EN) + P/2 + 3 cycles after RX_IN falls.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        case (typ)
            PAR_EVEN: expected_parity = ^d;
            PAR_ODD:  expected_parity = ~^d;
            default:  expected_parity = ^d;
        endcase
    endfunction

    rx_state_e                 state_r;
    logic                      rx_meta_r;
    logic                      rx_sync_r;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [BIT_W-1:0]          bit_cnt_r;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic                      par_en_r;
    logic                      par_typ_r;
    logic                      par_err_r;
    logic                      last_edge_s;
    logic                      sampled_bit_s;
    logic                      sample_done_s;

    assign last_edge_s = (edge_cnt_r == prescale_r - PRESCALE_WIDTH'(1));

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= RX_IN;
            rx_sync_r <= rx_meta_r;
        end
    end

    rx_bit_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk        (CLK),
        .rst_n      (RST),
        .rx         (rx_sync_r),
        .edge_cnt   (edge_cnt_r),
        .prescale   (prescale_r),
        .sampled_bit(sampled_bit_s),
        .sample_done(sample_done_s)
    );

    // Frame FSM with counters, shift register, parity check and result registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            edge_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            prescale_r   <= PRESCALE_WIDTH'(PRESCALE_DEFAULT);
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_err_r    <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            edge_cnt_r   <= last_edge_s ? '0 : edge_cnt_r + PRESCALE_WIDTH'(1);
            case (state_r)
                IDLE: begin
                    edge_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    par_err_r  <= 1'b0;
                    if (!rx_sync_r) begin
                        state_r    <= START;
                        prescale_r <= PRESCALE_WIDTH'(legal_prescale(32'(Prescale)));
                        par_en_r   <= PAR_EN;
                        par_typ_r  <= PAR_TYP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    // A high vote means the falling edge was a glitch
                    if (sample_done_s && sampled_bit_s) begin
                        state_r    <= IDLE;
                        edge_cnt_r <= '0;
                    end else if (last_edge_s) begin
                        state_r <= DATA;
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (sample_done_s) begin
                        shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (last_edge_s) begin
                        if (bit_cnt_r == BIT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_r <= '0;
                            state_r   <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                PARITY: begin
                    if (sample_done_s) begin
                        par_err_r <= (sampled_bit_s != expected_parity(shift_r, par_typ_r));
                    end else begin
                        par_err_r <= par_err_r;
                    end
                    if (last_edge_s) begin
                        state_r <= STOP;
                    end else begin
                        state_r <= PARITY;
                    end
                end
                STOP: begin
                    // Leave as soon as the stop vote is known so a back-to-back start is caught
                    if (sample_done_s) begin
                        state_r      <= IDLE;
                        edge_cnt_r   <= '0;
                        Parity_Error <= par_err_r;
                        Stop_Error   <= ~sampled_bit_s;
                        if (!par_err_r && sampled_bit_s) begin
                            P_DATA     <= shift_r;
                            Data_Valid <= 1'b1;
                        end else begin
                            P_DATA <= P_DATA;
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    edge_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames at several prescales, parity, glitch, stop error, reset.
module tb_uart_rx_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    int         cyc = 0;
    int         start_cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         perr_cnt = 0;
    int         serr_cnt = 0;
    logic [7:0] dv_data_q[$];
    int         dv_cyc_q[$];

    uart_rx_core dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every result pulse away from the active edge
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_data_q.push_back(P_DATA);
            dv_cyc_q.push_back(cyc);
        end
        if (Parity_Error) perr_cnt++;
        if (Stop_Error) serr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        idle(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                              input logic sbit, input int p);
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(sbit, p);
        RX_IN = 1'b1;
    endtask

    int b_dv, b_pe, b_se;

    task automatic snap();
        b_dv = dv_data_q.size();
        b_pe = perr_cnt;
        b_se = serr_cnt;
    endtask

    initial begin
        idle(3);
        check("reset_pdata", 32'(P_DATA), 32'h0);
        check("reset_dv", 32'(Data_Valid), 32'h0);
        check("reset_perr", 32'(Parity_Error), 32'h0);
        check("reset_serr", 32'(Stop_Error), 32'h0);
        RST = 1'b1;
        idle(4);

        // 1: P=8, no parity, 0xA5
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        idle(20);
        check("t1_dv_count", 32'(dv_data_q.size() - b_dv), 32'd1);
        check("t1_data", 32'(dv_data_q[b_dv]), 32'hA5);
        check("t1_latency", 32'(dv_cyc_q[b_dv] - start_cyc), 32'd82);
        check("t1_perr", 32'(perr_cnt - b_pe), 32'd0);
        check("t1_serr", 32'(serr_cnt - b_se), 32'd0);
        check("t1_pdata_hold", 32'(P_DATA), 32'hA5);

        // 2: P=16, even parity, 0x3C good then bad parity
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        idle(20);
        check("t2_dv_count", 32'(dv_data_q.size() - b_dv), 32'd1);
        check("t2_data", 32'(dv_data_q[b_dv]), 32'h3C);
        check("t2_latency", 32'(dv_cyc_q[b_dv] - start_cyc), 32'd174);
        check("t2_perr_none", 32'(perr_cnt - b_pe), 32'd0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        idle(20);
        check("t2b_perr", 32'(perr_cnt - b_pe), 32'd1);
        check("t2b_dv_none", 32'(dv_data_q.size() - b_dv), 32'd0);
        check("t2b_serr", 32'(serr_cnt - b_se), 32'd0);
        check("t2b_pdata_hold", 32'(P_DATA), 32'h3C);

        // 3: P=32, odd parity, 0x01 with parity bit 0
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 32);
        idle(20);
        check("t3_dv_count", 32'(dv_data_q.size() - b_dv), 32'd1);
        check("t3_latency", 32'(dv_cyc_q[b_dv] - start_cyc), 32'd342);
        check("t3_pdata", 32'(P_DATA), 32'h01);

        // 4: glitch then 0x55 at P=8
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        RX_IN = 1'b0;
        idle(3);
        RX_IN = 1'b1;
        idle(30);
        check("t4_glitch_dv", 32'(dv_data_q.size() - b_dv), 32'd0);
        check("t4_glitch_err", 32'((perr_cnt - b_pe) + (serr_cnt - b_se)), 32'd0);
        check("t4_glitch_pdata", 32'(P_DATA), 32'h01);
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8);
        idle(20);
        check("t4_dv_count", 32'(dv_data_q.size() - b_dv), 32'd1);
        check("t4_data", 32'(dv_data_q[b_dv]), 32'h55);

        // 5: stop error, then back-to-back frames
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8);
        idle(30);
        check("t5_serr", 32'(serr_cnt - b_se), 32'd1);
        check("t5_dv_none", 32'(dv_data_q.size() - b_dv), 32'd0);
        check("t5_pdata_hold", 32'(P_DATA), 32'h55);
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 8);
        idle(20);
        check("t5_b2b_count", 32'(dv_data_q.size() - b_dv), 32'd2);
        check("t5_b2b_first", 32'(dv_data_q[b_dv]), 32'h12);
        check("t5_b2b_second", 32'(dv_data_q[b_dv + 1]), 32'h34);
        check("t5_b2b_latency", 32'(dv_cyc_q[b_dv + 1] - start_cyc), 32'd82);

        // 6: reset in the middle of a 0x77 frame
        snap();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        RST = 1'b0;
        #1;
        check("t6_rst_pdata", 32'(P_DATA), 32'h0);
        check("t6_rst_dv", 32'(Data_Valid), 32'h0);
        check("t6_rst_perr", 32'(Parity_Error), 32'h0);
        check("t6_rst_serr", 32'(Stop_Error), 32'h0);
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(120);
        check("t6_no_pulse", 32'(dv_data_q.size() - b_dv), 32'd0);
        check("t6_no_err", 32'((perr_cnt - b_pe) + (serr_cnt - b_se)), 32'd0);
        Prescale = 6'd5;
        snap();
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 8);
        idle(20);
        check("t6_dv_count", 32'(dv_data_q.size() - b_dv), 32'd1);
        check("t6_data", 32'(dv_data_q[b_dv]), 32'h77);
        check("t6_latency_p5", 32'(dv_cyc_q[b_dv] - start_cyc), 32'd82);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
